// File: rtl/conv_pkg.sv
// Shared types and default sizing for the parametrised 1-D convolution engine.
package conv_pkg;

  typedef enum logic [1:0] {
    LOAD,
    COMPUTE,
    OUTPUT
  } state_t;

  // Default configuration: 16 samples, 4 taps, 16-bit data.
  localparam int N_DEF = 16;
  localparam int M_DEF = 4;
  localparam int T_DEF = 16;

  // Derived sizes for the default configuration.
  localparam int ACC_W = 2 * T_DEF + $clog2(M_DEF);
  localparam int NOUT  = N_DEF - M_DEF + 1;
  localparam int XA_W  = $clog2(N_DEF);
  localparam int FA_W  = $clog2(M_DEF);

  // Saturation bounds for a T_DEF-bit signed result.
  localparam longint SAT_MAX = (longint'(1) <<< (T_DEF - 1)) - 1;
  localparam longint SAT_MIN = -(longint'(1) <<< (T_DEF - 1));

endpackage

// File: rtl/conv_mem.sv
// Small register-file memory: one synchronous write port, one asynchronous read port.
module conv_mem #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [WIDTH-1:0]         wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [WIDTH-1:0]         rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Store a word whenever the owner signals an accepted write.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/conv_param.sv
// 1-D convolution engine: loads x and a persistent filter f, then streams y[i] = sum x[i+j]*f[j].
module conv_param
  import conv_pkg::*;
#(
  parameter int N    = N_DEF,
  parameter int M    = M_DEF,
  parameter int T    = T_DEF,
  parameter bit SAT  = 1'b1,
  parameter bit RELU = 1'b0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [T-1:0] s_data_in_x,
  input  logic         s_valid_x,
  output logic         s_ready_x,
  input  logic [T-1:0] s_data_in_f,
  input  logic         s_valid_f,
  output logic         s_ready_f,
  output logic [T-1:0] m_data_out_y,
  output logic         m_valid_y,
  input  logic         m_ready_y
);

  localparam int ACC_W = 2 * T + $clog2(M);
  localparam int XA_W  = $clog2(N);
  localparam int FA_W  = $clog2(M);

  localparam logic [XA_W-1:0] X_LAST = XA_W'(N - 1);
  localparam logic [XA_W-1:0] I_LAST = XA_W'(N - M);
  localparam logic [FA_W-1:0] F_LAST = FA_W'(M - 1);

  localparam logic signed [ACC_W-1:0] SAT_HI = {{(ACC_W - T + 1){1'b0}}, {(T - 1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_LO = {{(ACC_W - T + 1){1'b1}}, {(T - 1){1'b0}}};

  state_t state;
  logic [XA_W-1:0] x_wa;
  logic [XA_W-1:0] i_cnt;
  logic [FA_W-1:0] f_wa;
  logic [FA_W-1:0] j_cnt;
  logic            x_full;
  logic            f_loaded;
  logic            mac_phase;
  logic signed [ACC_W-1:0] acc;

  logic                     x_hs;
  logic                     f_hs;
  logic                     y_hs;
  logic                     x_full_nxt;
  logic                     f_loaded_nxt;
  logic [XA_W-1:0]          x_ra;
  logic signed [T-1:0]      x_rd;
  logic signed [T-1:0]      f_rd;
  logic signed [2*T-1:0]    prod;
  logic signed [ACC_W-1:0]  acc_sum;
  logic [T-1:0]             res;

  assign x_hs = s_valid_x & s_ready_x;
  assign f_hs = s_valid_f & s_ready_f;
  assign y_hs = m_valid_y & m_ready_y;

  assign x_full_nxt   = x_full | (x_hs & (x_wa == X_LAST));
  assign f_loaded_nxt = f_loaded | (f_hs & (f_wa == F_LAST));

  assign x_ra    = i_cnt + XA_W'(j_cnt);
  assign prod    = x_rd * f_rd;
  assign acc_sum = acc + {{(ACC_W - 2 * T){prod[2*T-1]}}, prod};

  conv_mem #(.WIDTH(T), .DEPTH(N)) u_xmem (
    .clk   (clk),
    .we    (x_hs),
    .waddr (x_wa),
    .wdata (s_data_in_x),
    .raddr (x_ra),
    .rdata (x_rd)
  );

  conv_mem #(.WIDTH(T), .DEPTH(M)) u_fmem (
    .clk   (clk),
    .we    (f_hs),
    .waddr (f_wa),
    .wdata (s_data_in_f),
    .raddr (j_cnt),
    .rdata (f_rd)
  );

  // Reduce the final accumulator to T bits (clamp or wrap), then optionally zero negatives.
  always_comb begin
    res = acc_sum[T-1:0];
    if (SAT) begin
      if (acc_sum > SAT_HI)      res = SAT_HI[T-1:0];
      else if (acc_sum < SAT_LO) res = SAT_LO[T-1:0];
    end
    if (RELU && res[T-1]) res = '0;
  end

  // Controller and MAC datapath: load x/f, one clear cycle plus M MACs per output, hold y until taken.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= LOAD;
      x_wa         <= '0;
      f_wa         <= '0;
      i_cnt        <= '0;
      j_cnt        <= '0;
      x_full       <= 1'b0;
      f_loaded     <= 1'b0;
      mac_phase    <= 1'b0;
      acc          <= '0;
      s_ready_x    <= 1'b0;
      s_ready_f    <= 1'b0;
      m_valid_y    <= 1'b0;
      m_data_out_y <= '0;
    end else begin
      case (state)
        LOAD: begin
          if (x_hs) x_wa <= (x_wa == X_LAST) ? '0 : x_wa + 1'b1;
          if (f_hs) f_wa <= (f_wa == F_LAST) ? '0 : f_wa + 1'b1;
          x_full   <= x_full_nxt;
          f_loaded <= f_loaded_nxt;
          if (x_full_nxt && f_loaded_nxt) begin
            state     <= COMPUTE;
            mac_phase <= 1'b0;
            i_cnt     <= '0;
            s_ready_x <= 1'b0;
            s_ready_f <= 1'b0;
          end else begin
            s_ready_x <= !x_full_nxt;
            s_ready_f <= !f_loaded_nxt;
          end
        end
        COMPUTE: begin
          if (!mac_phase) begin
            acc       <= '0;
            j_cnt     <= '0;
            mac_phase <= 1'b1;
          end else begin
            acc <= acc_sum;
            if (j_cnt == F_LAST) begin
              m_data_out_y <= res;
              m_valid_y    <= 1'b1;
              state        <= OUTPUT;
            end else begin
              j_cnt <= j_cnt + 1'b1;
            end
          end
        end
        OUTPUT: begin
          if (y_hs) begin
            m_valid_y <= 1'b0;
            if (i_cnt == I_LAST) begin
              state     <= LOAD;
              x_full    <= 1'b0;
              s_ready_x <= 1'b1;
              s_ready_f <= !f_loaded;
            end else begin
              i_cnt     <= i_cnt + 1'b1;
              mac_phase <= 1'b0;
              state     <= COMPUTE;
            end
          end
        end
        default: state <= LOAD;
      endcase
    end
  end

endmodule

// File: tb/tb_conv_param.sv
// Directed bench for conv_param: three instances (saturate, wrap, saturate+ReLU) share one stimulus.
module tb_conv_param;
  import conv_pkg::*;

  localparam int N = N_DEF;
  localparam int M = M_DEF;
  localparam int T = T_DEF;

  logic clk = 1'b0;
  logic reset = 1'b0;

  logic [T-1:0] s_data_in_x;
  logic [T-1:0] s_data_in_f;
  logic         s_valid_x;
  logic         s_valid_f;
  logic         m_ready_y;

  logic         s_ready_x, s_ready_f, m_valid_y;
  logic [T-1:0] m_data_out_y;
  logic         rx_w, rf_w, v_w;
  logic [T-1:0] d_w;
  logic         rx_r, rf_r, v_r;
  logic [T-1:0] d_r;

  logic [T-1:0] x_vec [N];
  logic [T-1:0] f_vec [M];
  logic [T-1:0] exp_sat  [NOUT];
  logic [T-1:0] exp_wrap [NOUT];
  logic [T-1:0] exp_relu [NOUT];

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  conv_param #(.N(N), .M(M), .T(T), .SAT(1'b1), .RELU(1'b0)) dut (
    .clk(clk), .reset(reset),
    .s_data_in_x(s_data_in_x), .s_valid_x(s_valid_x), .s_ready_x(s_ready_x),
    .s_data_in_f(s_data_in_f), .s_valid_f(s_valid_f), .s_ready_f(s_ready_f),
    .m_data_out_y(m_data_out_y), .m_valid_y(m_valid_y), .m_ready_y(m_ready_y)
  );

  conv_param #(.N(N), .M(M), .T(T), .SAT(1'b0), .RELU(1'b0)) dut_wrap (
    .clk(clk), .reset(reset),
    .s_data_in_x(s_data_in_x), .s_valid_x(s_valid_x), .s_ready_x(rx_w),
    .s_data_in_f(s_data_in_f), .s_valid_f(s_valid_f), .s_ready_f(rf_w),
    .m_data_out_y(d_w), .m_valid_y(v_w), .m_ready_y(m_ready_y)
  );

  conv_param #(.N(N), .M(M), .T(T), .SAT(1'b1), .RELU(1'b1)) dut_relu (
    .clk(clk), .reset(reset),
    .s_data_in_x(s_data_in_x), .s_valid_x(s_valid_x), .s_ready_x(rx_r),
    .s_data_in_f(s_data_in_f), .s_valid_f(s_valid_f), .s_ready_f(rf_r),
    .m_data_out_y(d_r), .m_valid_y(v_r), .m_ready_y(m_ready_y)
  );

  // Single comparison point: count it, and report tag/observed/expected on mismatch.
  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Pulse reset for two cycles with all inputs idle.
  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    s_valid_x = 1'b0;
    s_valid_f = 1'b0;
    m_ready_y = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  // Feed x_vec and the first nf entries of f_vec concurrently; returns on the last handshake edge.
  task automatic apply_stimulus(input string tag, input int nf);
    int xi;
    int fi;
    int guard;
    logic hx;
    logic hf;
    xi = 0;
    fi = 0;
    guard = 0;
    while ((xi < N || fi < nf) && guard < 100) begin
      @(negedge clk);
      s_valid_x = (xi < N);
      s_data_in_x = '0;
      if (xi < N) s_data_in_x = x_vec[xi];
      s_valid_f = (fi < nf);
      s_data_in_f = '0;
      if (fi < nf) s_data_in_f = f_vec[fi];
      hx = s_valid_x && s_ready_x;
      hf = s_valid_f && s_ready_f;
      @(posedge clk);
      if (hx) xi++;
      if (hf) fi++;
      guard++;
    end
    check_output({tag, "_load_done"}, 32'(guard < 100), 32'd1);
  endtask

  // Wait for each output (bounded), check latency and data on all instances, optionally stall, then take it.
  task automatic collect(input string tag, input int nout, input bit hold);
    for (int k = 0; k < nout; k++) begin
      int n;
      n = 0;
      while (n < 50) begin
        @(negedge clk);
        s_valid_x = 1'b0;
        s_valid_f = 1'b0;
        if (m_valid_y) break;
        @(posedge clk);
        n++;
      end
      check_output($sformatf("%s_lat%0d", tag, k), 32'(n), 32'(M + 1));
      if (n >= 50) return;
      check_output($sformatf("%s_sat%0d", tag, k), 32'(m_data_out_y), 32'(exp_sat[k]));
      check_output($sformatf("%s_wrap%0d", tag, k), 32'(d_w), 32'(exp_wrap[k]));
      check_output($sformatf("%s_relu%0d", tag, k), 32'(d_r), 32'(exp_relu[k]));
      check_output($sformatf("%s_vld%0d", tag, k), {30'd0, v_w, v_r}, 32'd3);
      if (hold) begin
        m_ready_y = 1'b0;
        for (int h = 0; h < 10; h++) begin
          @(posedge clk);
          @(negedge clk);
          check_output($sformatf("%s_hold_vld%0d_%0d", tag, k, h), 32'(m_valid_y), 32'd1);
          check_output($sformatf("%s_hold_dat%0d_%0d", tag, k, h), 32'(m_data_out_y), 32'(exp_sat[k]));
          check_output($sformatf("%s_hold_rdy%0d_%0d", tag, k, h), 32'(s_ready_x), 32'd0);
        end
        m_ready_y = 1'b1;
      end
      @(posedge clk);
    end
  endtask

  // After the final y of a vector: x ready again next cycle, filter kept so f not ready.
  task automatic post_vector(input string tag);
    @(negedge clk);
    check_output({tag, "_rdy_x"}, 32'(s_ready_x), 32'd1);
    check_output({tag, "_rdy_f"}, 32'(s_ready_f), 32'd0);
  endtask

  // Hard stop in case the sequence below ever stalls.
  initial begin
    #400000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  // Directed sequence of steps.
  initial begin
    int seen;
    s_valid_x = 1'b0;
    s_valid_f = 1'b0;
    s_data_in_x = '0;
    s_data_in_f = '0;
    m_ready_y = 1'b1;
    reset = 1'b0;

    // Reset values and first edge after release
    repeat (2) @(negedge clk);
    check_output("rst_rdy_x", 32'(s_ready_x), 32'd0);
    check_output("rst_rdy_f", 32'(s_ready_f), 32'd0);
    check_output("rst_vld", 32'(m_valid_y), 32'd0);
    check_output("rst_dat", 32'(m_data_out_y), 32'd0);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check_output("rel_rdy_x", 32'(s_ready_x), 32'd1);
    check_output("rel_rdy_f", 32'(s_ready_f), 32'd1);

    // Identity filter
    f_vec[0] = 16'd1; f_vec[1] = 16'd0; f_vec[2] = 16'd0; f_vec[3] = 16'd0;
    for (int i = 0; i < N; i++) x_vec[i] = 16'(i);
    for (int i = 0; i < NOUT; i++) begin
      exp_sat[i] = 16'(i); exp_wrap[i] = 16'(i); exp_relu[i] = 16'(i);
    end
    apply_stimulus("ident", M);
    collect("ident", NOUT, 1'b0);
    post_vector("ident");

    // Persistent filter across two vectors
    do_reset();
    for (int j = 0; j < M; j++) f_vec[j] = 16'd1;
    for (int i = 0; i < N; i++) x_vec[i] = 16'd1;
    for (int i = 0; i < NOUT; i++) begin
      exp_sat[i] = 16'd4; exp_wrap[i] = 16'd4; exp_relu[i] = 16'd4;
    end
    apply_stimulus("pers1", M);
    collect("pers1", NOUT, 1'b0);
    post_vector("pers1");
    for (int i = 0; i < N; i++) x_vec[i] = 16'd2;
    for (int i = 0; i < NOUT; i++) begin
      exp_sat[i] = 16'd8; exp_wrap[i] = 16'd8; exp_relu[i] = 16'd8;
    end
    apply_stimulus("pers2", 0);
    collect("pers2", NOUT, 1'b0);
    post_vector("pers2");

    // Positive overflow: clamp vs wrap
    do_reset();
    for (int j = 0; j < M; j++) f_vec[j] = 16'h7FFF;
    for (int i = 0; i < N; i++) x_vec[i] = 16'h7FFF;
    for (int i = 0; i < NOUT; i++) begin
      exp_sat[i] = 16'h7FFF; exp_wrap[i] = 16'h0004; exp_relu[i] = 16'h7FFF;
    end
    apply_stimulus("satpos", M);
    collect("satpos", NOUT, 1'b0);

    // Negative overflow: clamp to minimum, wrap to zero, ReLU to zero
    do_reset();
    for (int j = 0; j < M; j++) f_vec[j] = 16'h8000;
    for (int i = 0; i < NOUT; i++) begin
      exp_sat[i] = 16'h8000; exp_wrap[i] = 16'h0000; exp_relu[i] = 16'h0000;
    end
    apply_stimulus("satneg", M);
    collect("satneg", NOUT, 1'b0);

    // ReLU with backpressure on every output
    do_reset();
    f_vec[0] = 16'hFFFF; f_vec[1] = 16'd0; f_vec[2] = 16'd0; f_vec[3] = 16'd0;
    for (int i = 0; i < N; i++) x_vec[i] = 16'(i);
    for (int i = 0; i < NOUT; i++) begin
      exp_sat[i] = 16'(-i); exp_wrap[i] = 16'(-i); exp_relu[i] = 16'd0;
    end
    apply_stimulus("relu", M);
    collect("relu", NOUT, 1'b1);
    post_vector("relu");

    // Reset in the middle of a vector
    do_reset();
    f_vec[0] = 16'd1; f_vec[1] = 16'd2; f_vec[2] = 16'd3; f_vec[3] = 16'd4;
    for (int i = 0; i < NOUT; i++) begin
      exp_sat[i] = 16'(10 * i + 20); exp_wrap[i] = 16'(10 * i + 20); exp_relu[i] = 16'(10 * i + 20);
    end
    apply_stimulus("mid", M);
    collect("mid", 5, 1'b0);
    @(negedge clk);
    #2 reset = 1'b0;
    #1;
    check_output("mid_rst_vld", 32'(m_valid_y), 32'd0);
    check_output("mid_rst_dat", 32'(m_data_out_y), 32'd0);
    check_output("mid_rst_rdy_x", 32'(s_ready_x), 32'd0);
    check_output("mid_rst_rdy_f", 32'(s_ready_f), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_output("mid_rel_rdy_f", 32'(s_ready_f), 32'd1);
    check_output("mid_rel_rdy_x", 32'(s_ready_x), 32'd1);
    seen = 0;
    repeat (20) begin
      @(negedge clk);
      if (m_valid_y) seen++;
    end
    check_output("mid_no_stale_y", 32'(seen), 32'd0);

    // Fresh load after the interrupted vector
    f_vec[0] = 16'd0; f_vec[1] = 16'd0; f_vec[2] = 16'd0; f_vec[3] = 16'd1;
    for (int i = 0; i < N; i++) x_vec[i] = 16'(i);
    for (int i = 0; i < NOUT; i++) begin
      exp_sat[i] = 16'(i + 3); exp_wrap[i] = 16'(i + 3); exp_relu[i] = 16'(i + 3);
    end
    apply_stimulus("fresh", M);
    collect("fresh", NOUT, 1'b0);
    post_vector("fresh");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
